// File: rtl/bytetype_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : bytetype_pkg                                                 |
// | Description : Shared state encoding, PS/2 prefix bytes and ASCII bounds   |
// |               used by the typing checker.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bytetype_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LOAD     = 3'd2,
        WAIT_KEY = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [6:0] ASCII_LO  = 7'd97;
    localparam logic [6:0] ASCII_HI  = 7'd122;

    // Only lowercase letters have a meaningful scan code in the LUT.
    function automatic logic is_lower(input logic [6:0] c);
        return (c >= ASCII_LO) && (c <= ASCII_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scan_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_scan_filter                                              |
// | Description : Strips F0/E0 prefixed sequences and holds one early make     |
// |               code until the checker is ready to compare it.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_scan_filter
    import bytetype_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       hold,
    input  logic       consume,
    input  logic       clear,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       make_valid,
    output logic [7:0] make_code
);

    logic       r_brk;
    logic       r_ext;
    logic       r_pend_v;
    logic [7:0] r_pend_code;
    logic       w_is_brk;
    logic       w_is_ext;
    logic       w_new_make;

    assign w_is_brk   = (scan_code == PS2_BREAK);
    assign w_is_ext   = (scan_code == PS2_EXT);
    assign w_new_make = active && scan_valid && !w_is_brk && !w_is_ext && !r_brk && !r_ext;

    // A fresh make code takes priority over a stale pending one.
    assign make_valid = consume && (w_new_make || r_pend_v);
    assign make_code  = w_new_make ? scan_code : r_pend_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_code <= 8'h00;
        end else begin
            if (active && scan_valid) begin
                if (w_is_brk) begin
                    r_brk <= 1'b1;
                end else if (w_is_ext) begin
                    r_ext <= 1'b1;
                end else begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            end
            if (clear || consume) begin
                r_pend_v <= 1'b0;
            end else if (hold && w_new_make) begin
                r_pend_v    <= 1'b1;
                r_pend_code <= scan_code;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/typing_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : typing_checker                                               |
// | Description : Walks a target text, compares PS/2 make codes against the    |
// |               ps2lut scan code and counts hits and misses.                 |
// |               Build option: TYPO_ADVANCE_EN (a miss also advances).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module typing_checker
    import bytetype_pkg::*;
#(
    parameter int TEXT_LEN = 32,
    parameter int IDX_W    = 5,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] text_addr,
    input  logic [6:0]       text_char,
    output logic [6:0]       lut_key,
    input  logic [7:0]       lut_value,
    input  logic             scan_valid,
    input  logic [7:0]       scan_code,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic             miss,
    output logic [IDX_W-1:0] cursor,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [IDX_W-1:0] c_last    = IDX_W'(TEXT_LEN - 1);
    localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
`ifdef TYPO_ADVANCE_EN
    localparam bit c_typo_adv = 1'b1;
`else
    localparam bit c_typo_adv = 1'b0;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_cursor;
    logic [IDX_W-1:0] w_cursor_nxt;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] w_hit_cnt_nxt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic [CNT_W-1:0] w_miss_cnt_nxt;
    logic [6:0]       r_char_q;
    logic [6:0]       w_char_nxt;
    logic             w_hit;
    logic             w_miss;
    logic             w_clear;
    logic             w_advance;
    logic             w_make_valid;
    logic [7:0]       w_make_code;

    ps2_scan_filter u_filter (
        .clk        (clk),
        .reset      (reset),
        .active     (r_state != IDLE),
        .hold       ((r_state == FETCH) || (r_state == LOAD)),
        .consume    (r_state == WAIT_KEY),
        .clear      (w_clear),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .make_valid (w_make_valid),
        .make_code  (w_make_code)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cursor_nxt   = r_cursor;
        w_hit_cnt_nxt  = r_hit_cnt;
        w_miss_cnt_nxt = r_miss_cnt;
        w_char_nxt     = r_char_q;
        w_hit          = 1'b0;
        w_miss         = 1'b0;
        w_clear        = 1'b0;
        w_advance      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_clear        = 1'b1;
                    w_cursor_nxt   = '0;
                    w_hit_cnt_nxt  = '0;
                    w_miss_cnt_nxt = '0;
                    w_state_nxt    = FETCH;
                end
            end
            FETCH: w_state_nxt = LOAD;
            LOAD: begin
                w_char_nxt = text_char;
                if (is_lower(text_char)) begin
                    w_state_nxt = WAIT_KEY;
                end else begin
                    w_advance = 1'b1;
                end
            end
            WAIT_KEY: begin
                if (w_make_valid) begin
                    if (w_make_code == lut_value) begin
                        w_hit         = 1'b1;
                        w_advance     = 1'b1;
                        w_hit_cnt_nxt = (&r_hit_cnt) ? r_hit_cnt : r_hit_cnt + c_cnt_one;
                    end else begin
                        w_miss         = 1'b1;
                        w_advance      = c_typo_adv;
                        w_miss_cnt_nxt = (&r_miss_cnt) ? r_miss_cnt : r_miss_cnt + c_cnt_one;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // The last character parks the cursor and ends the pass.
        if (w_advance) begin
            if (r_cursor == c_last) begin
                w_state_nxt = DONE;
            end else begin
                w_cursor_nxt = r_cursor + c_idx_one;
                w_state_nxt  = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cursor   <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_char_q   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cursor   <= w_cursor_nxt;
            r_hit_cnt  <= w_hit_cnt_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
            r_char_q   <= w_char_nxt;
        end
    end

    assign text_addr = r_cursor;
    assign lut_key   = r_char_q;
    assign cursor    = r_cursor;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;
    assign hit       = w_hit;
    assign miss      = w_miss;
    assign busy      = (r_state != IDLE) && (r_state != DONE);
    assign done      = (r_state == DONE);

endmodule
`default_nettype wire
